mpu_regbank: RTL and testbench

MPU_REGBANK -- requirements
Module: mpu_regbank

---
 rtl/mpu_regbank.sv | 181 ++++++++++++++++++
 tb/tb_mpu_regbank.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_regbank.sv
// Purpose : multi-port register bank with field-granular writes, sequential bank clear and optional shadow bank.
// Latency : reads are combinational; an accepted write is visible from the next cycle; clear takes NB_REG cycles.
// Backpressure: w_ready drops while clearing, while en is low, and on cycles that start a clear or restore.
//
// Optional feature: define MPU_REGBANK_SHADOW_EN to add a shadow bank with single-edge save/restore.
//
// Ports:
//   sys_clk, sys_rst_n         clock, asynchronous active-low reset
//   en                         global enable for write/clear/save/restore
//   r_idx0..3 / r_data0..3     four combinational read ports
//   w_valid/w_ready            write handshake
//   w_idx, w_data              destination register, source word
//   w_size, w_sel, w_r_sel     field width 8<<w_size, source field, destination field
//   clr, save, restore         bank clear / shadow save / shadow restore request pulses
//   busy, done, err            clear in progress, clear finished pulse, rejected-request pulse
module mpu_regbank #(
    parameter  int NB_REG = 32,
    parameter  int DW     = 64,
    localparam int IW     = $clog2(NB_REG)
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          en,
    input  logic [IW-1:0] r_idx0,
    input  logic [IW-1:0] r_idx1,
    input  logic [IW-1:0] r_idx2,
    input  logic [IW-1:0] r_idx3,
    output logic [DW-1:0] r_data0,
    output logic [DW-1:0] r_data1,
    output logic [DW-1:0] r_data2,
    output logic [DW-1:0] r_data3,
    input  logic          w_valid,
    output logic          w_ready,
    input  logic [IW-1:0] w_idx,
    input  logic [DW-1:0] w_data,
    input  logic [1:0]    w_size,
    input  logic [2:0]    w_sel,
    input  logic [2:0]    w_r_sel,
    input  logic          clr,
    input  logic          save,
    input  logic          restore,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] regs [NB_REG];
    logic [IW-1:0] clr_cnt_q;
    logic          last_clr;
    logic          idle;

    // Reset and clear value: everything zero except the top register, which holds 1.
    function automatic logic [DW-1:0] rst_val(input int i);
        return (i == NB_REG - 1) ? DW'(1) : '0;
    endfunction

    assign idle     = (state_q == IDLE);
    assign last_clr = (clr_cnt_q == IW'(NB_REG - 1));

    assign r_data0 = regs[r_idx0];
    assign r_data1 = regs[r_idx1];
    assign r_data2 = regs[r_idx2];
    assign r_data3 = regs[r_idx3];

    // Shadow control. Without the shadow bank, save/restore are inert and
    // restore must not hold off writes.
    logic save_go;
    logic restore_go;
    logic sr_conflict;
    logic restore_block;

`ifdef MPU_REGBANK_SHADOW_EN
    logic [DW-1:0] shadow [NB_REG];

    assign sr_conflict   = en && idle && save && restore;
    assign save_go       = en && idle && save && !restore;
    assign restore_go    = en && idle && restore && !save;
    assign restore_block = restore;

    // Nonblocking semantics give the shadow the pre-write contents when a
    // write lands on the same edge as a save.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NB_REG; i++) shadow[i] <= rst_val(i);
        end else if (save_go) begin
            for (int i = 0; i < NB_REG; i++) shadow[i] <= regs[i];
        end
    end
`else
    logic unused_shadow_ports;

    assign sr_conflict         = 1'b0;
    assign save_go             = 1'b0;
    assign restore_go          = 1'b0;
    assign restore_block       = 1'b0;
    assign unused_shadow_ports = save | restore | save_go;
`endif

    // Control FSM: next state and handshake/status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        w_ready = 1'b0;
        case (state_q)
            IDLE: begin
                w_ready = en && !clr && !restore_block;
                if (clr && en) state_d = CLEAR;
            end
            CLEAR: begin
                busy = 1'b1;
                if (last_clr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Field decode. A field is legal only if both source and destination
    // slices lie fully inside the word; illegal writes are dropped.
    int            fw;
    int            src_lo;
    int            dst_lo;
    logic          w_bad;
    logic          w_acc;
    logic [DW-1:0] fmask;
    logic [DW-1:0] src_field;
    logic [DW-1:0] merged;

    always_comb begin
        fw        = 8 << w_size;
        src_lo    = int'(w_sel) * fw;
        dst_lo    = int'(w_r_sel) * fw;
        w_bad     = (fw > DW) || (src_lo + fw > DW) || (dst_lo + fw > DW);
        fmask     = (fw >= DW) ? '1 : ((DW'(1) << fw) - DW'(1));
        src_field = (w_data >> src_lo) & fmask;
        merged    = (regs[w_idx] & ~(fmask << dst_lo)) | (src_field << dst_lo);
    end

    assign w_acc = w_valid && w_ready;

    // Register array: reset, one-per-cycle clear, restore, field write.
    // Restore and write never coincide because restore holds w_ready low.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NB_REG; i++) regs[i] <= rst_val(i);
        end else if (state_q == CLEAR) begin
            regs[clr_cnt_q] <= rst_val(int'(clr_cnt_q));
        end else begin
`ifdef MPU_REGBANK_SHADOW_EN
            if (restore_go) begin
                for (int i = 0; i < NB_REG; i++) regs[i] <= shadow[i];
            end
`endif
            if (w_acc && !w_bad) regs[w_idx] <= merged;
        end
    end

    // State, clear pointer and registered status pulses.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= (state_q == CLEAR) && last_clr;
            err     <= (w_acc && w_bad) || sr_conflict;
            // The pointer wraps to 0 on the final clear cycle, ready for the next clear.
            if (state_q == CLEAR) clr_cnt_q <= clr_cnt_q + IW'(1);
            else                  clr_cnt_q <= '0;
        end
    end

endmodule

// File: tb/tb_mpu_regbank.sv
module tb_mpu_regbank;

    localparam int NB = 32;
    localparam int DW = 64;
    localparam int IW = 5;
`ifdef MPU_REGBANK_SHADOW_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          en        = 1'b0;
    logic [IW-1:0] r_idx0 = '0, r_idx1 = '0, r_idx2 = '0, r_idx3 = '0;
    logic [DW-1:0] r_data0, r_data1, r_data2, r_data3;
    logic          w_valid = 1'b0;
    logic          w_ready;
    logic [IW-1:0] w_idx   = '0;
    logic [DW-1:0] w_data  = '0;
    logic [1:0]    w_size  = '0;
    logic [2:0]    w_sel   = '0;
    logic [2:0]    w_r_sel = '0;
    logic          clr = 1'b0, save = 1'b0, restore = 1'b0;
    logic          busy, done, err;

    mpu_regbank dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .en       (en),
        .r_idx0   (r_idx0),
        .r_idx1   (r_idx1),
        .r_idx2   (r_idx2),
        .r_idx3   (r_idx3),
        .r_data0  (r_data0),
        .r_data1  (r_data1),
        .r_data2  (r_data2),
        .r_data3  (r_data3),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_idx    (w_idx),
        .w_data   (w_data),
        .w_size   (w_size),
        .w_sel    (w_sel),
        .w_r_sel  (w_r_sel),
        .clr      (clr),
        .save     (save),
        .restore  (restore),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Behavioural model: the bank contents plus clear progress and status pulses.
    logic [DW-1:0] m_regs [NB];
    logic [DW-1:0] m_sh   [NB];
    bit            m_busy;
    bit            m_done;
    bit            m_err;
    int            m_pos;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [63:0] rv(input int i);
        return (i == NB - 1) ? 64'd1 : 64'd0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NB; i++) begin
            m_regs[i] = rv(i);
            m_sh[i]   = rv(i);
        end
        m_busy = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_pos  = 0;
    endtask

    function automatic bit exp_wready();
        return en && !m_busy && !clr && !(SH && restore);
    endfunction

    // Apply one rising edge's worth of behaviour from the current inputs.
    task automatic m_update();
        logic [DW-1:0] old [NB];
        bit wr;
        int fw, s, rs;
        old = m_regs;
        wr  = w_valid && exp_wready();
        fw  = 8 * (1 << int'(w_size));
        s   = int'(w_sel);
        rs  = int'(w_r_sel);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (m_busy) begin
            m_regs[m_pos] = rv(m_pos);
            m_pos++;
            if (m_pos == NB) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (en) begin
            if (SH && save && restore) m_err = 1'b1;
            else begin
                if (SH && save)    m_sh   = old;
                if (SH && restore) m_regs = m_sh;
            end
            if (wr) begin
                if (fw > DW || (s + 1) * fw > DW || (rs + 1) * fw > DW) m_err = 1'b1;
                else for (int b = 0; b < fw; b++) m_regs[w_idx][rs * fw + b] = w_data[s * fw + b];
            end
            if (clr) begin
                m_busy = 1'b1;
                m_pos  = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        m_update();
        #2;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge sys_clk) begin
        if (chk_en) begin
            chk("w_ready", 64'(w_ready), 64'(exp_wready()));
            chk("busy",    64'(busy),    64'(m_busy));
            chk("done",    64'(done),    64'(m_done));
            chk("err",     64'(err),     64'(m_err));
            chk("r_data0", r_data0, m_regs[r_idx0]);
            chk("r_data1", r_data1, m_regs[r_idx1]);
            chk("r_data2", r_data2, m_regs[r_idx2]);
            chk("r_data3", r_data3, m_regs[r_idx3]);
        end
    end

    // Read every register and compare against the literal reset/clear image.
    task automatic check_bank(input string name);
        for (int g = 0; g < NB / 4; g++) begin
            r_idx0 = IW'(4 * g);
            r_idx1 = IW'(4 * g + 1);
            r_idx2 = IW'(4 * g + 2);
            r_idx3 = IW'(4 * g + 3);
            #1;
            chk(name, r_data0, rv(4 * g));
            chk(name, r_data1, rv(4 * g + 1));
            chk(name, r_data2, rv(4 * g + 2));
            chk(name, r_data3, rv(4 * g + 3));
            tick();
        end
    endtask

    task automatic do_write(input int idx, input logic [63:0] d, input int sz, input int s, input int rs);
        w_valid = 1'b1;
        w_idx   = IW'(idx);
        w_data  = d;
        w_size  = 2'(sz);
        w_sel   = 3'(s);
        w_r_sel = 3'(rs);
        tick();
        w_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nb, nd, nr, last_busy, done_at;
        m_reset();
        repeat (3) @(posedge sys_clk);
        #2 sys_rst_n = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        check_bank("rst_bank");
        en     = 1'b1;
        chk_en = 1'b1;

        // Field write: 16-bit field 1 of the source into field 2 of regs[3].
        do_write(3, 64'h1122334455667788, 1, 1, 2);
        r_idx0 = 5'd3;
        #1;
        chk("wr_field", r_data0, 64'h0000_5566_0000_0000);
        chk("wr_err", 64'(err), 64'd0);

        // Out-of-range source field: dropped, single err pulse.
        do_write(3, 64'hFFFF_FFFF_FFFF_FFFF, 2, 2, 0);
        #1;
        chk("bad_err", 64'(err), 64'd1);
        chk("bad_keep", r_data0, 64'h0000_5566_0000_0000);
        tick();
        chk("bad_err_clr", 64'(err), 64'd0);

        // Bank clear with nonzero contents and writes attempted during it.
        do_write(31, 64'h0, 3, 0, 0);
        do_write(17, 64'hDEAD_BEEF_0000_1234, 3, 0, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        w_idx = 5'd9; w_data = 64'hFF; w_size = 2'd0; w_sel = 3'd0; w_r_sel = 3'd0;
        nb = 0; nd = 0; nr = 0; last_busy = -1; done_at = -1;
        for (int k = 0; k < 40; k++) begin
            if (busy) begin nb++; last_busy = k; end
            if (busy && w_ready) nr++;
            if (done) begin nd++; done_at = k; end
            w_valid = busy;
            tick();
        end
        w_valid = 1'b0;
        chk("clr_busy_cycles", 64'(nb), 64'd32);
        chk("clr_wready_low", 64'(nr), 64'd0);
        chk("clr_done_count", 64'(nd), 64'd1);
        chk("clr_done_pos", 64'(done_at), 64'(last_busy + 1));
        check_bank("clr_bank");

`ifdef MPU_REGBANK_SHADOW_EN
        do_write(5, 64'hAA, 3, 0, 0);
        save = 1'b1;
        do_write(5, 64'hBB, 3, 0, 0);
        save = 1'b0;
        r_idx0 = 5'd5;
        #1;
        chk("save_wr_regs", r_data0, 64'hBB);
        restore = 1'b1;
        #1;
        chk("restore_wready", 64'(w_ready), 64'd0);
        tick();
        restore = 1'b0;
        #1;
        chk("restore_val", r_data0, 64'hAA);
        save = 1'b1; restore = 1'b1;
        tick();
        save = 1'b0; restore = 1'b0;
        #1;
        chk("sr_conflict_err", 64'(err), 64'd1);
`else
        do_write(5, 64'hAA, 3, 0, 0);
        save = 1'b1;
        do_write(5, 64'hBB, 3, 0, 0);
        save = 1'b0;
        restore = 1'b1;
        #1;
        chk("noshadow_wready", 64'(w_ready), 64'd1);
        tick();
        restore = 1'b0;
        r_idx0 = 5'd5;
        #1;
        chk("noshadow_val", r_data0, 64'hBB);
        chk("noshadow_err", 64'(err), 64'd0);
`endif
        tick();

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            int fw;
            en      = ($urandom_range(0, 9) != 0);
            w_valid = $urandom_range(0, 1) == 1;
            w_idx   = IW'($urandom_range(0, NB - 1));
            w_data  = {$urandom, $urandom};
            w_size  = 2'($urandom_range(0, 3));
            fw      = 8 << w_size;
            if ($urandom_range(0, 3) != 0) begin
                w_sel   = 3'($urandom_range(0, 64 / fw - 1));
                w_r_sel = 3'($urandom_range(0, 64 / fw - 1));
            end else begin
                w_sel   = 3'($urandom_range(0, 7));
                w_r_sel = 3'($urandom_range(0, 7));
            end
            clr     = ($urandom_range(0, 99) == 0);
            save    = ($urandom_range(0, 19) == 0);
            restore = ($urandom_range(0, 24) == 0);
            r_idx0  = IW'($urandom_range(0, NB - 1));
            r_idx1  = IW'($urandom_range(0, NB - 1));
            r_idx2  = IW'($urandom_range(0, NB - 1));
            r_idx3  = IW'($urandom_range(0, NB - 1));
            tick();
        end
        en = 1'b1; w_valid = 1'b0; clr = 1'b0; save = 1'b0; restore = 1'b0;
        tick();
        tick();

        // Reset in the middle of a clear aborts it at once.
        do_write(20, 64'h1234_5678, 3, 0, 0);
        do_write(31, 64'h0, 3, 0, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (9) tick();
        #1 sys_rst_n = 1'b0;
        chk_en = 1'b0;
        #1;
        chk("midclr_busy", 64'(busy), 64'd0);
        m_reset();
        r_idx0 = 5'd20;
        r_idx1 = 5'd31;
        #1;
        chk("midclr_r20", r_data0, 64'd0);
        chk("midclr_r31", r_data1, 64'd1);
        @(posedge sys_clk);
        #2 sys_rst_n = 1'b1;
        chk_en = 1'b1;
        tick();
        check_bank("post_rst_bank");

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
